song_reader: RTL and testbench

//  Consumer end of the mcu control interface. Takes play / reset_player / song

---
 rtl/song_reader_if.sv | 28 ++
 rtl/song_reader.sv | 94 +++++++++
 tb/tb_song_reader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/song_reader_if.sv
// Bundles the mcu, song-ROM and note_player signals seen by song_reader.
// The slave modport is the song_reader view; master is the surrounding system.
interface song_reader_if #(
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
);
  logic                    play;
  logic                    reset_player;
  logic [1:0]              song;
  logic                    song_done;
  logic [IDX_W+1:0]        rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note;
  logic [DUR_W-1:0]        duration;
  logic                    new_note;
  logic                    note_done;

  modport slave (
    input  play, reset_player, song, rom_data, note_done,
    output song_done, rom_addr, note, duration, new_note
  );

  modport master (
    output play, reset_player, song, rom_data, note_done,
    input  song_done, rom_addr, note, duration, new_note
  );
endinterface

// File: rtl/song_reader.sv
// Walks the selected song's notes in the song ROM and hands each one to
// note_player with a new_note/note_done handshake; pulses song_done at the end.
module song_reader #(
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  song_reader_if.slave     bus,
  output logic [2:0]       o_dbg_state,
  output logic [IDX_W-1:0] o_dbg_idx
);
  // Handshake: new_note is a 1-cycle pulse with note/duration valid; the
  // reader then waits in WAIT_NOTE until note_done, which is ignored elsewhere.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_ROM,
    ST_NEW_NOTE,
    ST_WAIT_NOTE,
    ST_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_next;
  logic [IDX_W+1:0]    r_rom_addr;
  logic [NOTE_W-1:0]   r_note;
  logic [DUR_W-1:0]    r_duration;
  logic [DUR_W-1:0]    w_rom_dur;

  assign w_rom_dur = bus.rom_data[DUR_W-1:0];

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (bus.reset_player) begin
      w_state_next = ST_IDLE;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE:     if (bus.play) w_state_next = ST_FETCH;
        ST_FETCH:    w_state_next = ST_WAIT_ROM;
        // A zero duration is the end-of-song marker and is never issued.
        ST_WAIT_ROM: w_state_next = (w_rom_dur == '0) ? ST_DONE : ST_NEW_NOTE;
        ST_NEW_NOTE: w_state_next = ST_WAIT_NOTE;
        ST_WAIT_NOTE: begin
          if (bus.note_done) begin
            if (r_idx == LAST_IDX) begin
              w_state_next = ST_DONE;
            end else begin
              w_idx_next   = r_idx + 1'b1;
              w_state_next = bus.play ? ST_FETCH : ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          w_idx_next   = '0;
          w_state_next = ST_IDLE;
        end
        default:     w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_rom_addr <= '0;
      r_note     <= '0;
      r_duration <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      // Address only moves when a fetch starts, so an idle reader never reads.
      if (w_state_next == ST_FETCH) r_rom_addr <= {bus.song, w_idx_next};
      if (r_state == ST_WAIT_ROM) {r_note, r_duration} <= bus.rom_data;
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.note      = r_note;
  assign bus.duration  = r_duration;
  assign bus.new_note  = (r_state == ST_NEW_NOTE) && !bus.reset_player;
  assign bus.song_done = (r_state == ST_DONE) && !bus.reset_player;

  assign o_dbg_state = r_state;
  assign o_dbg_idx   = r_idx;
endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: ROM model, note_player driver, and a scoreboard that
// pops the expected {note, duration} on every new_note pulse.
module tb_song_reader;
  localparam int IDX_W  = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int W      = NOTE_W + DUR_W;
  localparam int ST_IDLE = 0;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       dbg_state;
  logic [IDX_W-1:0] dbg_idx;

  song_reader_if #(.IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) sr_if ();

  song_reader #(.IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (sr_if),
    .o_dbg_state (dbg_state),
    .o_dbg_idx   (dbg_idx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- song ROM model (1-cycle read latency) ----------------
  logic [W-1:0] rom [0:127];
  always @(posedge clk) sr_if.rom_data <= rom[sr_if.rom_addr];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_err  = 0;
  int nn_cnt = 0;
  int sd_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (reset) begin
      if (sr_if.new_note) begin
        nn_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_new_note: got note=%0d dur=%0d, required no pulse",
                   sr_if.note, sr_if.duration);
        end else begin
          e = exp_q.pop_front();
          check("note_dur", int'({sr_if.note, sr_if.duration}), int'(e));
        end
      end
      if (sr_if.song_done) sd_cnt++;
      if (sr_if.new_note && sr_if.song_done) begin
        n_vec++;
        n_err++;
        $display("FAIL pulse_overlap: got new_note=1 song_done=1, required at most one");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mcu pairs every song change with reset_player; play is dropped too.
  task automatic restart(input logic [1:0] s);
    step();
    sr_if.song         = s;
    sr_if.play         = 1'b0;
    sr_if.reset_player = 1'b1;
    step();
    sr_if.reset_player = 1'b0;
  endtask

  // Counts rising edges until new_note or song_done is seen; note_done is a
  // single-cycle pulse, so it is cleared after the first edge.
  task automatic wait_event(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      sr_if.note_done = 1'b0;
      cyc++;
      @(negedge clk);
    end while (!(sr_if.new_note || sr_if.song_done) && cyc < 40);
  endtask

  task automatic next_note(input logic [6:0] a, output int cyc);
    exp_q.push_back(rom[a]);
    step();
    sr_if.note_done = 1'b1;
    wait_event(cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, int'(sr_if.rom_addr), 0);
    check({tag, "_note"},     int'(sr_if.note), 0);
    check({tag, "_duration"}, int'(sr_if.duration), 0);
    check({tag, "_new_note"}, int'(sr_if.new_note), 0);
    check({tag, "_song_done"},int'(sr_if.song_done), 0);
    check({tag, "_state"},    int'(dbg_state), ST_IDLE);
    check({tag, "_idx"},      int'(dbg_idx), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int n0;
    int s0;

    for (int a = 0; a < 128; a++) rom[a] = {6'((a * 5 + 3) % 64), 6'((a % 13) + 1)};
    rom[7'h20] = {6'd20, 6'd8};
    rom[7'h64] = {rom[7'h63][W-1:DUR_W], 6'd0};

    sr_if.play         = 1'b0;
    sr_if.reset_player = 1'b0;
    sr_if.song         = 2'd2;
    sr_if.note_done    = 1'b0;

    // Reset state, then 20 idle cycles with play=0 and a nonzero song.
    #12;
    check_all_zero("reset");
    step();
    reset = 1'b1;
    n0 = nn_cnt;
    repeat (20) step();
    check("idle_rom_addr", int'(sr_if.rom_addr), 0);
    check("idle_new_note_cnt", nn_cnt - n0, 0);

    // Song 1: first note {20, 8}, then idx 1.
    restart(2'd1);
    exp_q.push_back({6'd20, 6'd8});
    sr_if.play = 1'b1;
    wait_event(c);
    check("play_latency", c, 3);
    check("s1_rom_addr0", int'(sr_if.rom_addr), 'h20);
    check("s1_note0", int'(sr_if.note), 20);
    check("s1_dur0", int'(sr_if.duration), 8);
    next_note(7'h21, c);
    check("note_done_latency", c, 3);
    check("s1_rom_addr1", int'(sr_if.rom_addr), 'h21);

    // Full song 2: 32 notes then a single song_done.
    restart(2'd2);
    n0 = nn_cnt;
    s0 = sd_cnt;
    exp_q.push_back(rom[7'h40]);
    sr_if.play = 1'b1;
    wait_event(c);
    check("s2_lat0", c, 3);
    for (int i = 1; i < 32; i++) begin
      next_note(7'(64 + i), c);
      check("s2_lat", c, 3);
    end
    check("s2_rom_addr31", int'(sr_if.rom_addr), 'h5f);
    step();
    sr_if.note_done = 1'b1;
    sr_if.play      = 1'b0;
    wait_event(c);
    check("s2_done_latency", c, 1);
    check("s2_song_done", int'(sr_if.song_done), 1);
    step();
    check("s2_idx_after_done", int'(dbg_idx), 0);
    check("s2_state_after_done", int'(dbg_state), ST_IDLE);
    repeat (3) step();
    check("s2_new_note_cnt", nn_cnt - n0, 32);
    check("s2_song_done_cnt", sd_cnt - s0, 1);

    // Song 3 ends early on the zero-duration entry at idx 4.
    restart(2'd3);
    n0 = nn_cnt;
    s0 = sd_cnt;
    exp_q.push_back(rom[7'h60]);
    sr_if.play = 1'b1;
    wait_event(c);
    for (int i = 1; i < 4; i++) next_note(7'(96 + i), c);
    step();
    sr_if.note_done = 1'b1;
    wait_event(c);
    check("s3_end_latency", c, 3);
    check("s3_song_done", int'(sr_if.song_done), 1);
    check("s3_note", int'(sr_if.note), int'(rom[7'h63][W-1:DUR_W]));
    check("s3_duration", int'(sr_if.duration), 0);
    step();
    sr_if.play = 1'b0;
    repeat (3) step();
    check("s3_new_note_cnt", nn_cnt - n0, 4);
    check("s3_song_done_cnt", sd_cnt - s0, 1);

    // Pause: note_done with play=0 advances idx and parks in IDLE.
    restart(2'd0);
    n0 = nn_cnt;
    exp_q.push_back(rom[7'h00]);
    sr_if.play = 1'b1;
    wait_event(c);
    step();
    sr_if.play      = 1'b0;
    sr_if.note_done = 1'b1;
    step();
    sr_if.note_done = 1'b0;
    repeat (5) step();
    check("pause_state", int'(dbg_state), ST_IDLE);
    check("pause_idx", int'(dbg_idx), 1);
    check("pause_rom_addr", int'(sr_if.rom_addr), 0);
    check("pause_new_note_cnt", nn_cnt - n0, 1);
    exp_q.push_back(rom[7'h01]);
    sr_if.play = 1'b1;
    wait_event(c);
    check("resume_latency", c, 3);
    check("resume_rom_addr", int'(sr_if.rom_addr), 1);

    // reset_player together with note_done on idx 31: no song_done.
    for (int i = 2; i < 32; i++) next_note(7'(i), c);
    step();
    s0 = sd_cnt;
    sr_if.reset_player = 1'b1;
    sr_if.note_done    = 1'b1;
    step();
    sr_if.reset_player = 1'b0;
    sr_if.note_done    = 1'b0;
    sr_if.play         = 1'b0;
    repeat (5) step();
    check("rp_song_done_cnt", sd_cnt - s0, 0);
    check("rp_idx", int'(dbg_idx), 0);
    check("rp_state", int'(dbg_state), ST_IDLE);
    restart(2'd2);
    exp_q.push_back(rom[7'h40]);
    sr_if.play = 1'b1;
    wait_event(c);
    check("rp_restart_latency", c, 3);
    check("rp_restart_rom_addr", int'(sr_if.rom_addr), 'h40);

    // reset_player held for several cycles with play=1 keeps the reader idle.
    step();
    sr_if.reset_player = 1'b1;
    n0 = nn_cnt;
    repeat (4) step();
    check("rp_hold_state", int'(dbg_state), ST_IDLE);
    check("rp_hold_new_note_cnt", nn_cnt - n0, 0);
    sr_if.reset_player = 1'b0;
    exp_q.push_back(rom[7'h40]);
    wait_event(c);
    check("rp_hold_release_latency", c, 3);

    // Asynchronous reset mid-note clears everything immediately.
    step();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    sr_if.play = 1'b0;
    step();
    reset = 1'b1;
    n0 = nn_cnt;
    repeat (20) step();
    check("post_reset_rom_addr", int'(sr_if.rom_addr), 0);
    check("post_reset_new_note_cnt", nn_cnt - n0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
